// File: rtl/psg_write_arbiter.sv
// Round-robin arbiter for the PSG register-write port, with per-requester voice
// ownership filtering, merged enable register (reg 15) and a post-reset clear sweep.
module psg_write_arbiter #(
    parameter int NREQ    = 2,
    parameter int NVOICES = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           i_req_valid,
    input  logic [4*NREQ-1:0]         i_req_sel,
    input  logic [8*NREQ-1:0]         i_req_data,
    input  logic [NVOICES*NREQ-1:0]   i_own_mask,
    output logic [NREQ-1:0]           o_req_ready,
    output logic [3:0]                o_psg_sel,
    output logic [7:0]                o_psg_data,
    output logic                      o_psg_write,
    output logic [7:0]                o_drop_count,
    output logic                      o_busy_init
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [3:0]           r_init_cnt;
    logic [IDXW-1:0]      r_ptr;
    logic [NVOICES-1:0]   r_shadow;
    logic [7:0]           r_drop;
    logic [3:0]           r_psg_sel;
    logic [7:0]           r_psg_data;
    logic                 r_psg_write;

    logic [3:0]           w_sel_arr  [NREQ];
    logic [7:0]           w_data_arr [NREQ];
    logic [NVOICES-1:0]   w_own_arr  [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_sel_arr[gi]  = i_req_sel[4*gi +: 4];
            assign w_data_arr[gi] = i_req_data[8*gi +: 8];
            assign w_own_arr[gi]  = i_own_mask[NVOICES*gi +: NVOICES];
        end
    endgenerate

    // Round-robin search: iterate from farthest to nearest so the nearest valid
    // index after the pointer is the one that sticks.
    logic            w_found;
    logic [IDXW-1:0] w_gnt_idx;
    logic            w_grant;

    always_comb begin
        logic [IDXW-1:0] idx;
        idx       = '0;
        w_found   = 1'b0;
        w_gnt_idx = r_ptr;
        for (int k = NREQ; k >= 1; k--) begin
            idx = IDXW'((int'(r_ptr) + k) % NREQ);
            if (i_req_valid[idx]) begin
                w_found   = 1'b1;
                w_gnt_idx = idx;
            end
        end
    end

    // A request seen in the reset cycle must not be acknowledged.
    assign w_grant = w_found && (r_state == S_RUN) && !reset;

    always_comb begin
        o_req_ready = '0;
        if (w_grant) begin
            o_req_ready[w_gnt_idx] = 1'b1;
        end
    end

    logic [3:0]         w_g_sel;
    logic [7:0]         w_g_data;
    logic [NVOICES-1:0] w_g_own;
    logic               w_fwd;
    logic               w_en_wr;
    logic [NVOICES-1:0] w_new_shadow;
    logic [7:0]         w_out_data;

    assign w_g_sel  = w_sel_arr[w_gnt_idx];
    assign w_g_data = w_data_arr[w_gnt_idx];
    assign w_g_own  = w_own_arr[w_gnt_idx];

    always_comb begin
        w_fwd        = 1'b0;
        w_en_wr      = 1'b0;
        w_new_shadow = r_shadow;
        w_out_data   = w_g_data;
        if (w_g_sel < 4'd12) begin
            w_fwd = w_g_own[w_g_sel[1:0]];
        end else if (w_g_sel == 4'd15) begin
            // Only the requester's own enable bits change; others keep their last value.
            w_en_wr      = |w_g_own;
            w_fwd        = |w_g_own;
            w_new_shadow = (r_shadow & ~w_g_own) | (w_g_data[NVOICES-1:0] & w_g_own);
            w_out_data   = 8'(w_new_shadow);
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (r_state == S_INIT && r_init_cnt == 4'd15) begin
            w_state_next = S_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_init_cnt  <= 4'd0;
            r_ptr       <= IDXW'(NREQ - 1);
            r_shadow    <= '0;
            r_drop      <= 8'd0;
            r_psg_sel   <= 4'd0;
            r_psg_data  <= 8'd0;
            r_psg_write <= 1'b0;
        end else if (r_state == S_INIT) begin
            r_psg_write <= 1'b1;
            r_psg_sel   <= r_init_cnt;
            r_psg_data  <= 8'd0;
            r_init_cnt  <= r_init_cnt + 4'd1;
        end else begin
            r_psg_write <= w_grant && w_fwd;
            if (w_grant) begin
                r_ptr <= w_gnt_idx;
                if (w_fwd) begin
                    r_psg_sel  <= w_g_sel;
                    r_psg_data <= w_out_data;
                end else if (r_drop != 8'hFF) begin
                    r_drop <= r_drop + 8'd1;
                end
                if (w_en_wr) begin
                    r_shadow <= w_new_shadow;
                end
            end
        end
    end

    assign o_psg_sel    = r_psg_sel;
    assign o_psg_data   = r_psg_data;
    assign o_psg_write  = r_psg_write;
    assign o_drop_count = r_drop;
    assign o_busy_init  = (r_state == S_INIT);

endmodule

// File: tb/tb_psg_write_arbiter.sv
// Directed bench for psg_write_arbiter: a bench-side model predicts grants, drops and
// PSG writes; predicted writes are queued and matched as they appear on the PSG port.
module tb_psg_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [7:0]  req_sel;
    logic [15:0] req_data;
    logic [7:0]  own_mask;
    logic [1:0]  req_ready;
    logic [3:0]  psg_sel;
    logic [7:0]  psg_data;
    logic        psg_write;
    logic [7:0]  drop_count;
    logic        busy_init;

    always #5 clk = ~clk;

    psg_write_arbiter #(.NREQ(2), .NVOICES(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_req_valid  (req_valid),
        .i_req_sel    (req_sel),
        .i_req_data   (req_data),
        .i_own_mask   (own_mask),
        .o_req_ready  (req_ready),
        .o_psg_sel    (psg_sel),
        .o_psg_data   (psg_data),
        .o_psg_write  (psg_write),
        .o_drop_count (drop_count),
        .o_busy_init  (busy_init)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [11:0] exp_q[$];
    logic [3:0]  m_own [2];
    logic [3:0]  m_shadow;
    int          m_drop;
    int          m_ptr;
    int          m_init_left;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Every PSG write must match the oldest predicted write.
    always @(posedge clk) begin
        #1;
        if (psg_write === 1'b1) begin : mon
            logic [12:0] e;
            e = 13'h0;
            if (exp_q.size() > 0) e = {1'b1, exp_q.pop_front()};
            chk("psg_write", {19'd0, 1'b1, psg_sel, psg_data}, {19'd0, e});
            $display("write sel=%0d data=%h", psg_sel, psg_data);
        end
    end

    task automatic drop_inc();
        if (m_drop < 255) m_drop++;
    endtask

    task automatic do_cycle(input logic [1:0] v, input logic [3:0] s0, input logic [7:0] d0,
                            input logic [3:0] s1, input logic [7:0] d1);
        int         g;
        int         idx;
        logic [3:0] s;
        logic [7:0] d;
        logic [3:0] o;
        logic [1:0] er;
        @(posedge clk);
        #2;
        req_valid = v;
        req_sel   = {s1, s0};
        req_data  = {d1, d0};
        own_mask  = {m_own[1], m_own[0]};
        #1;
        g = -1;
        if (m_init_left == 0) begin
            for (int k = 1; k <= 2; k++) begin
                idx = (m_ptr + k) % 2;
                if (g < 0 && ((v >> idx) & 2'b01) != 2'b00) g = idx;
            end
        end
        er = (g < 0) ? 2'b00 : ((g == 0) ? 2'b01 : 2'b10);
        chk("busy_init", 32'(busy_init), 32'(m_init_left > 0));
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("drop_count", 32'(drop_count), 32'(m_drop));
        $display("cycle valid=%b ready=%b exp_ready=%b drop=%0d", v, req_ready, er, drop_count);
        if (m_init_left > 0) m_init_left--;
        if (g >= 0) begin
            m_ptr = g;
            s = (g == 1) ? s1 : s0;
            d = (g == 1) ? d1 : d0;
            o = m_own[g];
            if (s < 4'd12) begin
                if (o[s[1:0]]) exp_q.push_back({s, d});
                else drop_inc();
            end else if (s != 4'd15) begin
                drop_inc();
            end else if (o == 4'd0) begin
                drop_inc();
            end else begin
                m_shadow = (m_shadow & ~o) | (d[3:0] & o);
                exp_q.push_back({4'hF, 4'h0, m_shadow});
            end
        end
    endtask

    task automatic do_reset(input int n, input logic [1:0] v);
        @(posedge clk);
        #2;
        chk("queue_drained_before_reset", 32'(exp_q.size()), 32'd0);
        reset     = 1'b1;
        req_valid = v;
        #1;
        chk("ready_at_reset_assert", 32'(req_ready), 32'd0);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #3;
            chk("ready_in_reset", 32'(req_ready), 32'd0);
            chk("busy_in_reset", 32'(busy_init), 32'd1);
        end
        reset = 1'b0;
        chk("drop_after_reset", 32'(drop_count), 32'd0);
        chk("psg_write_after_reset", 32'(psg_write), 32'd0);
        chk("psg_sel_after_reset", 32'(psg_sel), 32'd0);
        $display("reset released busy=%b drop=%0d", busy_init, drop_count);
        m_ptr       = 1;
        m_shadow    = 4'd0;
        m_drop      = 0;
        m_init_left = 15;
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back({4'(i), 8'h00});
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 2'b00;
        req_sel   = 8'h00;
        req_data  = 16'h0000;
        m_own[0]  = 4'hF;
        m_own[1]  = 4'hF;
        own_mask  = 8'hFF;
        m_shadow  = 4'd0;
        m_drop    = 0;
        m_ptr     = 1;
        m_init_left = 15;

        // Power-up clear sweep, then first grant to requester 0.
        do_reset(3, 2'b11);
        repeat (16) do_cycle(2'b11, 4'd3, 8'hA0, 4'd7, 8'hB1);

        // Strict alternation with both requesters valid.
        for (int i = 0; i < 8; i++)
            do_cycle(2'b11, 4'(i), 8'(i * 3), 4'(i + 4), 8'(i * 5 + 1));

        // Ownership filtering.
        m_own[0] = 4'b0011;
        m_own[1] = 4'b1100;
        do_cycle(2'b10, 4'd0, 8'h00, 4'd1, 8'h55);
        do_cycle(2'b10, 4'd0, 8'h00, 4'd10, 8'h07);
        do_cycle(2'b01, 4'd12, 8'h99, 4'd0, 8'h00);
        do_cycle(2'b01, 4'd2, 8'h22, 4'd0, 8'h00);
        do_cycle(2'b00, 4'd0, 8'h00, 4'd0, 8'h00);

        // Enable register merge.
        do_cycle(2'b01, 4'd15, 8'hFF, 4'd0, 8'h00);
        do_cycle(2'b10, 4'd0, 8'h00, 4'd15, 8'h04);
        do_cycle(2'b01, 4'd15, 8'h00, 4'd0, 8'h00);
        m_own[0] = 4'b0000;
        do_cycle(2'b01, 4'd15, 8'hFF, 4'd0, 8'h00);
        m_own[0] = 4'b0011;
        do_cycle(2'b01, 4'd11, 8'h3C, 4'd0, 8'h00);

        // Overlapping ownership: both may write voice 0.
        m_own[0] = 4'hF;
        m_own[1] = 4'hF;
        do_cycle(2'b10, 4'd0, 8'h00, 4'd0, 8'h6E);
        do_cycle(2'b01, 4'd0, 8'h6F, 4'd0, 8'h00);
        m_own[0] = 4'b0011;
        m_own[1] = 4'b1100;

        // Reserved registers and drop counter saturation.
        repeat (300) do_cycle(2'b01, 4'd13, 8'h5A, 4'd0, 8'h00);
        do_cycle(2'b00, 4'd0, 8'h00, 4'd0, 8'h00);

        // Reset mid-stream: shadow (now 0100) and drop_count must be cleared.
        do_cycle(2'b01, 4'd0, 8'h12, 4'd0, 8'h00);
        do_reset(2, 2'b01);
        repeat (16) do_cycle(2'b01, 4'd15, 8'hFF, 4'd0, 8'h00);
        do_cycle(2'b00, 4'd0, 8'h00, 4'd0, 8'h00);
        do_cycle(2'b00, 4'd0, 8'h00, 4'd0, 8'h00);
        #2;
        chk("queue_drained_at_end", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
